// File: rtl/led_display_arbiter.sv
// led_display_arbiter
// Shares one 4-LED binary display among NUM_REQ requesters. A round-robin
// arbiter picks a requester, its 4-bit value is captured and shown for
// DWELL_CYCLES cycles, the owner gets an ack pulse on normal completion, and
// the display is blanked for BLANK_CYCLES cycles before the next arbitration.
// Every output comes straight from a flop.

module led_display_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DWELL_CYCLES = 100000000,
    parameter int BLANK_CYCLES = 10000000,
    localparam int IDXW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [4*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   ack,
    output logic [3:0]           bin_out,
    output logic                 bin_valid,
    output logic [IDXW-1:0]      active_idx
);

    // One counter serves both the dwell and the blank phases, so it is sized
    // for whichever of the two is longer.
    localparam int MAX_CNT = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNTW    = $clog2(MAX_CNT + 1);

    localparam logic [CNTW-1:0] DWELL_LAST = CNTW'(DWELL_CYCLES - 1);
    localparam logic [CNTW-1:0] BLANK_LAST = CNTW'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
    localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    // With no blanking configured, a finished dwell drops straight into IDLE,
    // which gives exactly one empty cycle (carrying the ack) before the next
    // owner appears.
    localparam state_t EXIT_STATE = (BLANK_CYCLES > 0) ? ST_BLANK : ST_IDLE;

    state_t            state_reg;
    logic [CNTW-1:0]   count_reg;
    logic [IDXW-1:0]   rr_ptr_reg;

    // ------------------------------------------------------------------
    // Requester value slices
    // ------------------------------------------------------------------
    logic [3:0] slot_data [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
            assign slot_data[gi] = req_data[4*gi +: 4];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin winner selection
    // The request vector is rotated so rr_ptr sits at bit 0. The lowest set
    // bit is isolated, then rotated back and folded onto NUM_REQ bits. This
    // yields the one-hot winner without a variable-length scan.
    // ------------------------------------------------------------------
    logic [2*NUM_REQ-1:0] req_rot_wide;
    logic [2*NUM_REQ-1:0] first_rot_wide;
    logic [2*NUM_REQ-1:0] first_back_wide;
    logic [NUM_REQ-1:0]   win_onehot;
    logic [IDXW-1:0]      win_idx;
    logic                 win_found;
    logic [IDXW-1:0]      rr_next;

    assign req_rot_wide    = {req, req} >> rr_ptr_reg;
    assign first_rot_wide  = req_rot_wide & ~(req_rot_wide - {{(2*NUM_REQ-1){1'b0}}, 1'b1});
    assign first_back_wide = first_rot_wide << rr_ptr_reg;
    assign win_onehot      = first_back_wide[2*NUM_REQ-1:NUM_REQ] | first_back_wide[NUM_REQ-1:0];
    assign win_found       = |req;

    // Encode the one-hot winner into an index.
    always_comb begin
        win_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_onehot[k]) begin
                win_idx = win_idx | IDXW'(k);
            end
        end
    end

    // The pointer moves to the slot just past the winner, wrapping at the top.
    assign rr_next = (win_idx == LAST_IDX) ? '0 : (win_idx + IDXW'(1));

    // ------------------------------------------------------------------
    // Phase decode
    // ------------------------------------------------------------------
    logic show_done;
    logic show_abort;
    logic arb_now;

    // On the last dwell cycle, completion takes precedence over a dropped
    // request, so the ack is still issued.
    assign show_done  = (state_reg == ST_SHOW) && (count_reg == DWELL_LAST);
    assign show_abort = (state_reg == ST_SHOW) && ((req & grant) == '0);
    assign arb_now    = (state_reg == ST_IDLE) ||
                        ((state_reg == ST_BLANK) && (count_reg == BLANK_LAST));

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    // Sequence IDLE -> SHOW -> BLANK, capturing the winner's value at grant time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            count_reg  <= '0;
            rr_ptr_reg <= '0;
            grant      <= '0;
            ack        <= '0;
            bin_out    <= 4'h0;
            bin_valid  <= 1'b0;
            active_idx <= '0;
        end else begin
            // The ack lasts one cycle. It is raised only on the exit edge of a
            // completed dwell, for the requester that held the display.
            ack <= show_done ? grant : '0;

            if (show_done || show_abort) begin
                // Leave SHOW. The display is released on this edge, so there
                // is never a cycle that shows two owners.
                state_reg <= EXIT_STATE;
                count_reg <= '0;
                grant     <= '0;
                bin_out   <= 4'h0;
                bin_valid <= 1'b0;
            end else if (arb_now && win_found) begin
                // New owner. Its value is frozen here for the whole dwell.
                state_reg  <= ST_SHOW;
                count_reg  <= '0;
                grant      <= win_onehot;
                bin_out    <= slot_data[win_idx];
                bin_valid  <= 1'b1;
                active_idx <= win_idx;
                rr_ptr_reg <= rr_next;
            end else if (arb_now) begin
                // Nobody is asking. Wait in IDLE, where arbitration runs
                // every cycle.
                state_reg <= ST_IDLE;
                count_reg <= '0;
            end else begin
                // Mid-dwell or mid-blank: keep counting.
                count_reg <= count_reg + CNTW'(1);
            end
        end
    end

endmodule
